// File: rtl/main_control_fsm_pkg.sv
// Purpose : shared opcode, ALUOp and state encodings for the multicycle main control unit.
// Latency : n/a (definitions only).
// Backpr. : n/a.
package main_control_fsm_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LDI  = 6'b000001;
    localparam logic [OPC_W-1:0] OP_LD   = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ST   = 6'b000011;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OPC_W-1:0] OP_JMP  = 6'b000110;
    localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

    // ALUOp codes understood by the ALU control stage
    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_PASS1 = 3'b001;
    localparam logic [2:0] ALU_PASS2 = 3'b011;
    localparam logic [2:0] ALU_BEQ   = 3'b100;
    localparam logic [2:0] ALU_BNE   = 3'b101;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM    = 4'd3,
        ST_WB     = 4'd4,
        ST_HALT   = 4'd5,
        ST_FAULT  = 4'd6
    } state_e;

    // Defined opcodes are the contiguous block 0..JMP plus HALT.
    function automatic logic is_defined_op(input logic [OPC_W-1:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    function automatic logic [2:0] aluop_of(input logic [OPC_W-1:0] op);
        case (op)
            OP_LDI:       return ALU_PASS2;
            OP_LD, OP_ST: return ALU_PASS1;
            OP_BEQ:       return ALU_BEQ;
            OP_BNE:       return ALU_BNE;
            default:      return ALU_FUNCT;
        endcase
    endfunction

endpackage

// File: rtl/main_control_fsm_mem_wait_timer.sv
// Purpose : counts cycles a memory request waits without ready; flags expiry at limit-1.
// Latency : expired_o is combinational from the registered count.
// Backpr. : none; clear_i has priority over enable_i; limit 0 never expires.
// Ports   : clk_i, rst_i (sync, active-high), clear_i, enable_i, limit_i -> expired_o
module mem_wait_timer #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires on the cycle that would be the limit-th waiting cycle.
    assign expired_o = (limit_i != '0) && (cnt_q == limit_i - W'(1));

endmodule

// File: rtl/main_control_fsm.sv
// Purpose : multicycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, ALUOp and datapath strobes.
// Latency : JMP 2, BEQ/BNE 3, R/LDI/ST 4, LD 5 cycles with ready asserted immediately.
// Backpr. : req held until ready; WAIT_LIMIT cycles without ready -> FAULT (sticky until reset).
// Ports   : clock, reset (sync, active-high), instr_opcode, imem_ready, dmem_ready, alu_cond ->
//           ALUOp, ir_write, pc_inc, pc_load, pc_src, reg_write, mem_to_reg, imem_req, dmem_req,
//           dmem_we, halted, bus_error, illegal_op, state
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int OPW        = 6,
    parameter int WAIT_LIMIT = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [OPW-1:0] instr_opcode,
    input  logic           imem_ready,
    input  logic           dmem_ready,
    input  logic           alu_cond,
    output logic [2:0]     ALUOp,
    output logic           ir_write,
    output logic           pc_inc,
    output logic           pc_load,
    output logic           pc_src,
    output logic           reg_write,
    output logic           mem_to_reg,
    output logic           imem_req,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic           halted,
    output logic           bus_error,
    output logic           illegal_op,
    output logic [3:0]     state
);

    localparam int LIM_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic               halted_q, bus_err_q;
    logic [OPC_W-1:0]   dec_op;
    logic               tmr_expired;

    logic [2:0] alu_c;
    logic ir_wr_c, pc_inc_c, pc_ld_c, pc_src_c, reg_wr_c, m2r_c;
    logic ireq_c, dreq_c, dwe_c, ill_c;

    assign dec_op = OPC_W'(instr_opcode);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        alu_c    = ALU_FUNCT;
        ir_wr_c  = 1'b0;
        pc_inc_c = 1'b0;
        pc_ld_c  = 1'b0;
        pc_src_c = 1'b0;
        reg_wr_c = 1'b0;
        m2r_c    = 1'b0;
        ireq_c   = 1'b0;
        dreq_c   = 1'b0;
        dwe_c    = 1'b0;
        ill_c    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ireq_c = 1'b1;
                // Ready on the expiry cycle still completes the fetch.
                if (imem_ready) begin
                    ir_wr_c  = 1'b1;
                    pc_inc_c = 1'b1;
                    state_d  = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                op_d = dec_op;
                if (dec_op == OP_JMP) begin
                    pc_ld_c  = 1'b1;
                    pc_src_c = 1'b1;
                    state_d  = ST_FETCH;
                end else if (dec_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (!is_defined_op(dec_op)) begin
                    ill_c   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_c = aluop_of(op_q);
                case (op_q)
                    OP_R, OP_LDI: state_d = ST_WB;
                    OP_LD, OP_ST: state_d = ST_MEM;
                    default: begin
                        // BEQ/BNE: the ALU has already evaluated the condition.
                        pc_ld_c = alu_cond;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                alu_c  = aluop_of(op_q);
                dreq_c = 1'b1;
                dwe_c  = (op_q == OP_ST);
                if (dmem_ready) begin
                    state_d = (op_q == OP_LD) ? ST_WB : ST_FETCH;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                alu_c    = aluop_of(op_q);
                reg_wr_c = 1'b1;
                m2r_c    = (op_q == OP_LD);
                state_d  = ST_FETCH;
            end
            ST_HALT, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            if (state_d == ST_HALT || state_d == ST_FAULT) begin
                halted_q <= 1'b1;
            end
            if (state_d == ST_FAULT) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Any state change restarts the count, so FETCH and MEM each start from zero.
    mem_wait_timer #(.W(LIM_W)) u_timer (
        .clk_i     (clock),
        .rst_i     (reset),
        .clear_i   (state_d != state_q),
        .enable_i  ((ireq_c & ~imem_ready) | (dreq_c & ~dmem_ready)),
        .limit_i   (LIM_W'(WAIT_LIMIT)),
        .expired_o (tmr_expired)
    );

    // Reset is synchronous, so outputs are forced low combinationally while it is high;
    // this drops any in-flight request in the reset cycle itself.
    assign ALUOp      = reset ? 3'b000 : alu_c;
    assign ir_write   = ir_wr_c   & ~reset;
    assign pc_inc     = pc_inc_c  & ~reset;
    assign pc_load    = pc_ld_c   & ~reset;
    assign pc_src     = pc_src_c  & ~reset;
    assign reg_write  = reg_wr_c  & ~reset;
    assign mem_to_reg = m2r_c     & ~reset;
    assign imem_req   = ireq_c    & ~reset;
    assign dmem_req   = dreq_c    & ~reset;
    assign dmem_we    = dwe_c     & ~reset;
    assign illegal_op = ill_c     & ~reset;
    assign halted     = halted_q  & ~reset;
    assign bus_error  = bus_err_q & ~reset;
    assign state      = reset ? 4'd0 : state_q;

endmodule
